idli_sqi_arb: RTL and testbench
===============================

# idli_sqi_arb

Arbitrating SQI memory controller for the idli core. It shares the single external quad-SPI RAM between two requesters: instruction fetch and data load/store. It serialises each accepted request into a complete SQI transaction on the `uio` pins: chip-select, command, address, optional dummy phase, then data. It sits between the core and the pad mapping in `tt_um_theultimat_idli_top`.

## Interface
Parameters:
- `ADDR_W`, default 16: byte address width; must be a multiple of 4.
- `DATA_W`, default 16: transfer width per request; must be a multiple of 4.
- `GAP_CYCLES`, default 2: minimum chip-select-high cycles between transactions; must be ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: fetch read request; held until granted.
- `fetch_addr` in ADDR_W: fetch byte address.
- `fetch_gnt` out 1: one-cycle pulse; request accepted, address captured.
- `fetch_done` out 1: one-cycle pulse; `rdata` is valid.
- `data_req` in 1: data request; held until granted.
- `data_we` in 1: 1 = write, 0 = read.
- `data_addr` in ADDR_W: data byte address.
- `data_wdata` in DATA_W: write data.
- `data_gnt` out 1: one-cycle accept pulse.
- `data_done` out 1: one-cycle completion pulse (reads and writes).
- `rdata` out DATA_W: read result; holds until the next read completes.
- `busy` out 1: high from the cycle after a grant until the gap ends.
- `sqi_sck` out 1: serial clock.
- `sqi_cs` out 1: chip select, active low.
- `sqi_sio_out` out 4: output nibble.
- `sqi_sio_oe` out 4: output enables (all-0 or all-1).
- `sqi_sio_in` in 4: input nibble.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, GAP.
- **IDLE**: if any request is pending, grant one, capture address, `we` and wdata, then go to CMD.
- **Arbitration**: two-way round-robin.
  - On simultaneous requests, grant the requester not granted last.
  - After reset, data wins the first tie.
  - A lone request is granted regardless of history.
- **Command byte**: 0x03 for read, 0x02 for write; sent as 2 nibbles, high nibble first.
- **ADDR**: ADDR_W/4 nibbles, MSB first.
- **DUMMY** (reads only): 2 nibbles with `sqi_sio_oe`=0, so the bus turns around.
- **DATA**: DATA_W/4 nibbles, MSB first.
  - Writes drive wdata with `oe`=4'hF.
  - Reads keep `oe`=0 and shift `sqi_sio_in` into rdata, MSB nibble first.
- **`sqi_sio_oe`**: 4'hF during CMD, ADDR and write DATA; 0 otherwise.
- **`sqi_sio_out`**: 0 when not driving.
- **GAP**: `sqi_cs`=1, `sqi_sck`=0, for GAP_CYCLES cycles; then IDLE.
- **Requests during a transaction**: not granted; no gnt while busy. A request still held is served after GAP.
- **Reset** (including mid-transaction): all outputs return immediately to their reset values:
  - `sqi_cs`=1, `sqi_sck`=0, `sio_out`=0, `oe`=0;
  - gnt, done and busy = 0; `rdata`=0.
  - The in-flight transaction is abandoned with no done pulse. Arbitration history resets to data-first.

## Timing
- Grant in cycle T. Registered outputs take effect from T+1.
- Nibble k (k=0 is the first command nibble) occupies two cycles:
  - T+1+2k: `sck`=0, nibble driven;
  - T+2+2k: `sck`=1, same nibble.
- `sqi_cs`=0 from T+1 through the final sck-high cycle.
- Read nibbles are sampled on the clock edge ending the sck-high cycle.
- N = 2 + ADDR_W/4 + DATA_W/4, plus 2 for reads. With defaults: write N=10, read N=12.
- Done pulses in cycle D = T+2N+1, which is also the first GAP cycle (`cs`=1). `rdata` is valid in D.
  - Default write: done at T+21.
  - Default read: done at T+25.
- Earliest next grant: D+GAP_CYCLES, i.e. T+2N+1+GAP_CYCLES.
- gnt and done are never asserted in the same cycle for the same requester.

## Structure
- Package `idli_sqi_pkg`:
  - state enum;
  - `SQI_CMD_READ`=8'h03 and `SQI_CMD_WRITE`=8'h02;
  - requester-id enum (FETCH, DATA).
- Sub-module `idli_sqi_rr_arb`: 2-way round-robin arbiter.
  - Inputs: req[1:0], accept.
  - Output: one-hot gnt.
  - Holds a last-grant flip-flop.
- The top level contains:
  - FSM;
  - nibble counter sized to the maximum N;
  - shift register of 8 + ADDR_W + DATA_W bits;
  - sck toggle register.

## Test plan
- Data read, addr 16'h1234, memory model returns 16'hBEEF.
  - Command nibbles 0,3; address nibbles 1,2,3,4; oe=0 for 2 dummy nibbles.
  - data_done at T+25 with rdata=16'hBEEF.
- Data write 16'hA5C3 to addr 16'h0010.
  - Nibbles 0,2,0,0,1,0,A,5,C,3 with oe=4'hF.
  - data_done at T+21; cs high at T+21.
- fetch_req and data_req asserted together from reset:
  - data granted first, fetch granted at D+2;
  - on the next tie, data is granted after fetch.
- fetch_req alone, held high for three transactions: grants back to back, spaced exactly 2N+1+GAP_CYCLES=27 cycles apart.
- Assert rst_n low at nibble 5 of a read:
  - cs=1, sck=0, oe=0 in the same cycle;
  - no done pulse; the next tie goes to data.
- Check sck period: exactly 2 clocks during cs low; sck=0 whenever cs=1.

Source files
------------

// File: rtl/idli_sqi_pkg.sv
// Shared types and command constants for the idli SQI memory controller.
// Imported by the arbiter and by the controller top level.
package idli_sqi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } sqi_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/idli_sqi_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// After reset the fetch side counts as last granted, so data wins the first tie.
module idli_sqi_rr_arb
  import idli_sqi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  req_id_e last;

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req == 2'b11) begin
        gnt = (last == REQ_DATA) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_FETCH;
    end else if (accept && (req != 2'b00)) begin
      last <= gnt[1] ? REQ_DATA : REQ_FETCH;
    end
  end

endmodule

// File: rtl/idli_sqi_arb.sv
// Arbitrating SQI controller: serialises fetch and data requests into
// command/address/dummy/data nibble transactions on a single quad-SPI RAM.
module idli_sqi_arb
  import idli_sqi_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sqi_sck,
  output logic              sqi_cs,
  output logic [3:0]        sqi_sio_out,
  output logic [3:0]        sqi_sio_oe,
  input  logic [3:0]        sqi_sio_in
);

  localparam int A_NIB = ADDR_W / 4;
  localparam int D_NIB = DATA_W / 4;
  localparam int N_WR  = 2 + A_NIB + D_NIB;
  localparam int N_RD  = N_WR + 2;
  localparam int NW    = $clog2(N_RD + 1);
  localparam int SW    = 8 + ADDR_W + DATA_W;
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  localparam logic [NW-1:0] CMD_END   = NW'(1);
  localparam logic [NW-1:0] ADDR_END  = NW'(1 + A_NIB);
  localparam logic [NW-1:0] DUMMY_END = NW'(3 + A_NIB);
  localparam logic [NW-1:0] WR_END    = NW'(N_WR - 1);
  localparam logic [NW-1:0] RD_END    = NW'(N_RD - 1);
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_CYCLES - 1);

  sqi_state_e        state, next_state;
  logic [NW-1:0]     nib;
  logic [GW-1:0]     gap_cnt;
  logic              sck;
  logic [SW-1:0]     shreg;
  logic              we;
  req_id_e           owner;
  logic [DATA_W-1:0] rdata_q;
  logic              fetch_done_q, data_done_q;

  logic [1:0]        gnt_vec;
  logic              accept, grant, drive;
  req_id_e           grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [NW-1:0]     last_nib;
  logic [3:0]        shift_in;

  idli_sqi_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({data_req, fetch_req}),
    .accept (accept),
    .gnt    (gnt_vec)
  );

  assign accept   = (state == S_IDLE);
  assign grant    = |gnt_vec;
  assign grant_id = gnt_vec[1] ? REQ_DATA : REQ_FETCH;
  assign sel_we   = gnt_vec[1] & data_we;
  assign sel_addr = gnt_vec[1] ? data_addr : fetch_addr;
  assign last_nib = we ? WR_END : RD_END;
  assign shift_in = (state == S_DATA && !we) ? sqi_sio_in : 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A nibble finishes on the edge that ends its sck-high cycle.
  always_comb begin
    next_state = state;
    drive      = 1'b0;
    sqi_cs     = 1'b1;
    case (state)
      S_IDLE: begin
        if (grant) next_state = S_CMD;
      end
      S_CMD: begin
        sqi_cs = 1'b0;
        drive  = 1'b1;
        if (sck && nib == CMD_END) next_state = S_ADDR;
      end
      S_ADDR: begin
        sqi_cs = 1'b0;
        drive  = 1'b1;
        if (sck && nib == ADDR_END) next_state = we ? S_DATA : S_DUMMY;
      end
      S_DUMMY: begin
        sqi_cs = 1'b0;
        if (sck && nib == DUMMY_END) next_state = S_DATA;
      end
      S_DATA: begin
        sqi_cs = 1'b0;
        drive  = we;
        if (sck && nib == last_nib) next_state = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_END) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib          <= '0;
      gap_cnt      <= '0;
      sck          <= 1'b0;
      shreg        <= '0;
      we           <= 1'b0;
      owner        <= REQ_FETCH;
      rdata_q      <= '0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            shreg <= {sel_we ? SQI_CMD_WRITE : SQI_CMD_READ, sel_addr,
                      sel_we ? data_wdata : {DATA_W{1'b0}}};
            we    <= sel_we;
            owner <= grant_id;
            nib   <= '0;
            sck   <= 1'b0;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          sck <= ~sck;
          if (sck) begin
            nib <= nib + 1'b1;
            // Dummy nibbles leave the shifter alone so read data lands in the low bits.
            if (state != S_DUMMY) shreg <= {shreg[SW-5:0], shift_in};
            if (state == S_DATA && nib == last_nib) begin
              if (!we) rdata_q <= DATA_W'({shreg, sqi_sio_in});
              fetch_done_q <= (owner == REQ_FETCH);
              data_done_q  <= (owner == REQ_DATA);
              gap_cnt      <= '0;
            end
          end
        end
        S_GAP: begin
          sck     <= 1'b0;
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: sck <= 1'b0;
      endcase
    end
  end

  assign fetch_gnt   = gnt_vec[0];
  assign data_gnt    = gnt_vec[1];
  assign fetch_done  = fetch_done_q;
  assign data_done   = data_done_q;
  assign rdata       = rdata_q;
  assign busy        = (state != S_IDLE);
  assign sqi_sck     = sck;
  assign sqi_sio_oe  = {4{drive}};
  assign sqi_sio_out = drive ? shreg[SW-1:SW-4] : 4'h0;

endmodule

// File: tb/tb_idli_sqi_arb.sv
// Self-checking bench for idli_sqi_arb: a transaction-level model (nibble list,
// sparse memory, round-robin history) predicts every bus cycle, grant and done.
module tb_idli_sqi_arb;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int GAP    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_gnt, fetch_done;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [15:0] data_addr = '0;
  logic [15:0] data_wdata = '0;
  logic        data_gnt, data_done;
  logic [15:0] rdata;
  logic        busy, sqi_sck, sqi_cs;
  logic [3:0]  sqi_sio_out, sqi_sio_oe;
  logic [3:0]  sqi_sio_in = '0;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          last_data = 1'b0;
  bit          waiting = 1'b0;
  int          next_grant = 0;
  logic [15:0] exp_rdata = '0;
  logic [15:0] mem [logic [15:0]];

  idli_sqi_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
    .rdata(rdata), .busy(busy),
    .sqi_sck(sqi_sck), .sqi_cs(sqi_cs), .sqi_sio_out(sqi_sio_out),
    .sqi_sio_oe(sqi_sio_oe), .sqi_sio_in(sqi_sio_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] bus_now();
    return {sqi_cs, sqi_sck, sqi_sio_oe, sqi_sio_out, busy,
            fetch_gnt, data_gnt, fetch_done, data_done};
  endfunction

  function automatic logic [14:0] bus_exp(input logic cs, input logic sck, input logic [3:0] oe,
                                          input logic [3:0] o, input logic b, input logic fg,
                                          input logic dg, input logic fd, input logic dd);
    return {cs, sck, oe, o, b, fg, dg, fd, dd};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_req = 1'b0;
    data_req = 1'b0;
    sqi_sio_in = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_bus", bus_now(), bus_exp(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("reset_rdata", rdata, 0);
    rst_n = 1'b1;
    last_data = 1'b0;
    waiting = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  // Waits for one grant, then follows the whole transaction cycle by cycle.
  task automatic applyStimulus(input bit hold, output int gcyc, output bit gdata);
    bit          fr, dr, exp_d, we;
    logic [15:0] addr, wd, rv, val;
    logic [3:0]  nibs[$];
    bit          drv;
    int          k, n;
    #1;
    for (int w = 0; w < 60 && !(fetch_gnt || data_gnt); w++) begin
      @(negedge clk);
      #1;
    end
    if (!(fetch_gnt || data_gnt)) begin
      checkOutput("grant_timeout", 0, 1);
      fetch_req = 1'b0;
      data_req = 1'b0;
      gcyc = cyc;
      gdata = 1'b0;
      waiting = 1'b0;
      return;
    end
    gcyc  = cyc;
    fr    = fetch_req;
    dr    = data_req;
    exp_d = dr && (!fr || !last_data);
    checkOutput("grant_who", {fetch_gnt, data_gnt}, {!exp_d, exp_d});
    checkOutput("grant_busy", busy, 0);
    if (waiting) checkOutput("grant_spacing", gcyc, next_grant);
    gdata     = exp_d;
    last_data = exp_d;
    we   = exp_d ? data_we : 1'b0;
    addr = exp_d ? data_addr : fetch_addr;
    wd   = data_wdata;
    rv   = mem.exists(addr) ? mem[addr] : 16'($urandom);
    nibs.push_back(4'h0);
    nibs.push_back(we ? 4'h2 : 4'h3);
    for (int j = 3; j >= 0; j--) nibs.push_back(addr[4*j +: 4]);
    if (!we) begin
      nibs.push_back(4'h0);
      nibs.push_back(4'h0);
    end
    val = we ? wd : rv;
    for (int j = 3; j >= 0; j--) nibs.push_back(val[4*j +: 4]);
    n = nibs.size();
    for (int i = 1; i <= 2 * n; i++) begin
      @(negedge clk);
      k = (i - 1) / 2;
      if (i == 1 && !hold) begin
        if (exp_d) data_req = 1'b0;
        else fetch_req = 1'b0;
      end
      if (i % 2 == 1) sqi_sio_in = (!we && k >= n - 4) ? nibs[k] : 4'($urandom);
      drv = (k < 6) || we;
      #1;
      checkOutput("nibble_bus", bus_now(),
                  bus_exp(0, (i % 2 == 0), drv ? 4'hF : 4'h0, drv ? nibs[k] : 4'h0, 1, 0, 0, 0, 0));
    end
    @(negedge clk);
    #1;
    if (!we) exp_rdata = rv;
    else mem[addr] = wd;
    checkOutput("done_bus", bus_now(), bus_exp(1, 0, 0, 0, 1, 0, 0, !exp_d, exp_d));
    checkOutput("rdata", rdata, exp_rdata);
    for (int g = 1; g < GAP; g++) begin
      @(negedge clk);
      #1;
      checkOutput("gap_bus", bus_now(), bus_exp(1, 0, 0, 0, 1, 0, 0, 0, 0));
    end
    waiting    = fetch_req || data_req;
    next_grant = gcyc + 2 * n + 1 + GAP;
  endtask

  initial begin
    int  g0, g1, g2, cnt, t0;
    bit  d;

    do_reset();

    // Directed read and write from the memory-model examples.
    mem[16'h1234] = 16'hBEEF;
    data_addr = 16'h1234;
    data_we   = 1'b0;
    data_req  = 1'b1;
    applyStimulus(0, g0, d);
    checkOutput("read_rdata_beef", rdata, 16'hBEEF);

    data_addr  = 16'h0010;
    data_wdata = 16'hA5C3;
    data_we    = 1'b1;
    data_req   = 1'b1;
    applyStimulus(0, g0, d);
    checkOutput("write_stored", mem[16'h0010], 16'hA5C3);

    // Tie from reset: data first, then fetch right after the gap, then data again.
    do_reset();
    fetch_addr = 16'h0040;
    data_addr  = 16'h0050;
    data_we    = 1'b0;
    fetch_req  = 1'b1;
    data_req   = 1'b1;
    applyStimulus(0, g0, d);
    checkOutput("tie1_data", d, 1);
    applyStimulus(0, g1, d);
    checkOutput("tie1_fetch", d, 0);
    checkOutput("tie1_fetch_at_gap_end", g1 - g0, 2 * 12 + 1 + GAP);
    fetch_req = 1'b1;
    data_req  = 1'b1;
    applyStimulus(0, g0, d);
    checkOutput("tie2_data", d, 1);
    applyStimulus(0, g0, d);

    // Lone fetch held for three back-to-back transactions.
    fetch_addr = 16'h0100;
    fetch_req  = 1'b1;
    applyStimulus(1, g0, d);
    applyStimulus(1, g1, d);
    applyStimulus(1, g2, d);
    fetch_req = 1'b0;
    checkOutput("fetch_spacing_1", g1 - g0, 27);
    checkOutput("fetch_spacing_2", g2 - g1, 27);

    // Reset asserted during nibble 5 of a read.
    repeat (3) @(negedge clk);
    data_addr = 16'h2000;
    data_we   = 1'b0;
    data_req  = 1'b1;
    #1;
    for (int w = 0; w < 20 && !data_gnt; w++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("mid_grant", data_gnt, 1);
    t0 = cyc;
    @(negedge clk);
    data_req = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("mid_cycle", cyc - t0, 11);
    checkOutput("mid_cs_low", sqi_cs, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_bus", bus_now(), bus_exp(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("mid_reset_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_data = 1'b0;
    waiting = 1'b0;
    exp_rdata = '0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (fetch_done || data_done) cnt++;
    end
    checkOutput("no_done_after_reset", cnt, 0);
    fetch_req = 1'b1;
    data_req  = 1'b1;
    applyStimulus(0, g0, d);
    checkOutput("post_reset_tie_data", d, 1);
    applyStimulus(0, g0, d);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 14; it++) begin
      fetch_addr = 16'h0300 + 16'(2 * $urandom_range(0, 3));
      data_addr  = 16'h0300 + 16'(2 * $urandom_range(0, 3));
      data_we    = 1'($urandom_range(0, 1));
      data_wdata = 16'($urandom);
      fetch_req  = 1'($urandom_range(0, 1));
      data_req   = 1'($urandom_range(0, 1));
      if (!fetch_req && !data_req) data_req = 1'b1;
      for (int guard = 0; guard < 3 && (fetch_req || data_req); guard++) begin
        applyStimulus(0, g0, d);
      end
      fetch_req = 1'b0;
      data_req  = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
